uart_cmd_deframer: RTL

Byte-level command deframer that sits directly downstream of the UART receiver and upstream of the SPI-flash programming engine. It consumes received bytes, finds frame boundaries, extracts opcode, 24-bit address and length, and streams payload bytes to the flash engine. It verifies an 8-bit checksum and answers every frame with a one-byte ACK or NAK through the UART transmitter handshake.

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_cmd_deframer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command deframer
package uart_cmd_pkg;

   // Frame parser states, one per wire field plus idle/response
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_OPC,
      ST_A2,
      ST_A1,
      ST_A0,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_RESP
   } deframerState_t;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;
   localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
   localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

   localparam int ADDR_W = 24;
   localparam int LEN_W  = 8;

endpackage

// File: rtl/uart_cmd_deframer.sv
// rtl/uart_cmd_deframer.sv - byte deframer: header extraction, payload stream, checksum, ACK/NAK
module uart_cmd_deframer
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter logic [7:0] ACK_BYTE  = DEF_ACK_BYTE,
   parameter logic [7:0] NAK_BYTE  = DEF_NAK_BYTE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_data_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_endofpacket,
   output logic              cmd_valid,
   output logic [7:0]        cmd_opcode,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LEN_W-1:0]  cmd_len,
   output logic              pl_valid,
   output logic [7:0]        pl_data,
   output logic              frm_done,
   output logic              frm_ok,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic [7:0]        err_count
);

   deframerState_t state, stateNext;

   // Header fields are collected in shadows so cmd_* stay stable until the next cmd_valid
   logic [7:0]        opcShadow, opcShadowNext;
   logic [ADDR_W-1:0] addrShadow, addrShadowNext;
   logic [7:0]        sum, sumNext;
   logic [LEN_W-1:0]  remain, remainNext;

   logic              cmdValidNext, plValidNext, frmDoneNext, frmOkNext, txStartNext;
   logic [7:0]        cmdOpcodeNext, plDataNext, txDataNext, errCountNext;
   logic [ADDR_W-1:0] cmdAddrNext;
   logic [LEN_W-1:0]  cmdLenNext;

   logic              inFrame;
   logic              abortHit;
   logic [7:0]        sumWithByte;

   // A byte strobe wins over a simultaneous end-of-packet
   assign abortHit    = rx_endofpacket && !rx_data_ready;
   assign inFrame     = (state != ST_IDLE) && (state != ST_RESP);
   assign sumWithByte = sum + rx_data;

   // Next-state and next-output decode; every register holds unless a field arrives
   always_comb begin
      stateNext      = state;
      opcShadowNext  = opcShadow;
      addrShadowNext = addrShadow;
      sumNext        = sum;
      remainNext     = remain;
      cmdValidNext   = 1'b0;
      cmdOpcodeNext  = cmd_opcode;
      cmdAddrNext    = cmd_addr;
      cmdLenNext     = cmd_len;
      plValidNext    = 1'b0;
      plDataNext     = pl_data;
      frmDoneNext    = 1'b0;
      frmOkNext      = frm_ok;
      txStartNext    = 1'b0;
      txDataNext     = tx_data;
      errCountNext   = err_count;

      if (inFrame && abortHit) begin
         frmDoneNext = 1'b1;
         frmOkNext   = 1'b0;
         stateNext   = ST_RESP;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
                  sumNext   = 8'h00;
                  stateNext = ST_OPC;
               end
            end
            ST_OPC: begin
               if (rx_data_ready) begin
                  opcShadowNext = rx_data;
                  sumNext       = sumWithByte;
                  stateNext     = ST_A2;
               end
            end
            ST_A2: begin
               if (rx_data_ready) begin
                  addrShadowNext[23:16] = rx_data;
                  sumNext               = sumWithByte;
                  stateNext             = ST_A1;
               end
            end
            ST_A1: begin
               if (rx_data_ready) begin
                  addrShadowNext[15:8] = rx_data;
                  sumNext              = sumWithByte;
                  stateNext            = ST_A0;
               end
            end
            ST_A0: begin
               if (rx_data_ready) begin
                  addrShadowNext[7:0] = rx_data;
                  sumNext             = sumWithByte;
                  stateNext           = ST_LEN;
               end
            end
            ST_LEN: begin
               if (rx_data_ready) begin
                  sumNext       = sumWithByte;
                  cmdValidNext  = 1'b1;
                  cmdOpcodeNext = opcShadow;
                  cmdAddrNext   = addrShadow;
                  cmdLenNext    = rx_data;
                  remainNext    = rx_data;
                  stateNext     = (rx_data != 8'h00) ? ST_PAYLOAD : ST_CSUM;
               end
            end
            ST_PAYLOAD: begin
               if (rx_data_ready) begin
                  sumNext     = sumWithByte;
                  plValidNext = 1'b1;
                  plDataNext  = rx_data;
                  remainNext  = remain - 8'd1;
                  if (remain == 8'd1) begin
                     stateNext = ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (rx_data_ready) begin
                  frmDoneNext = 1'b1;
                  frmOkNext   = (sumWithByte == 8'h00);
                  stateNext   = ST_RESP;
               end
            end
            ST_RESP: begin
               // frm_ok was registered on entry, so it already selects the response byte
               if (!tx_busy) begin
                  txStartNext = 1'b1;
                  txDataNext  = frm_ok ? ACK_BYTE : NAK_BYTE;
                  if (!frm_ok && (err_count != 8'hFF)) begin
                     errCountNext = err_count + 8'd1;
                  end
                  stateNext = ST_IDLE;
               end
            end
            default: stateNext = ST_IDLE;
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         opcShadow  <= 8'h00;
         addrShadow <= '0;
         sum        <= 8'h00;
         remain     <= '0;
         cmd_valid  <= 1'b0;
         cmd_opcode <= 8'h00;
         cmd_addr   <= '0;
         cmd_len    <= '0;
         pl_valid   <= 1'b0;
         pl_data    <= 8'h00;
         frm_done   <= 1'b0;
         frm_ok     <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         err_count  <= 8'h00;
      end else begin
         state      <= stateNext;
         opcShadow  <= opcShadowNext;
         addrShadow <= addrShadowNext;
         sum        <= sumNext;
         remain     <= remainNext;
         cmd_valid  <= cmdValidNext;
         cmd_opcode <= cmdOpcodeNext;
         cmd_addr   <= cmdAddrNext;
         cmd_len    <= cmdLenNext;
         pl_valid   <= plValidNext;
         pl_data    <= plDataNext;
         frm_done   <= frmDoneNext;
         frm_ok     <= frmOkNext;
         tx_start   <= txStartNext;
         tx_data    <= txDataNext;
         err_count  <= errCountNext;
      end
   end

endmodule
